mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_pkg.sv | 16 +
 rtl/rr_pick2.sv | 17 +
 rtl/mem_bus_arbiter.sv | 89 ++++++++
 tb/tb_mem_bus_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and default widths for the instruction/data memory bus arbiter.
//   arb_state_t : arbiter FSM states
//   ADDR_W_DEF  : default address width
//   DATA_W_DEF  : default data width
package mem_bus_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick.
//   req   : [0] = ibus, [1] = dbus
//   last  : 1 when dbus was served last
//   grant : one-hot winner (same bit order as req), 0 when nobody requests
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    // On a tie the side that was not served last wins.
    if (req == 2'b11) grant = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates a hart's instruction-fetch bus and load/store bus onto a single
// memory port. One transaction in flight at a time, round-robin on ties.
//   clk, rst                    : clock, synchronous active-low reset
//   ibus__req/addr              : fetch request (held until ibus__rdy)
//   ibus__rdy/rdata             : fetch completion pulse + data
//   dbus__req/addr/wmask/wdata  : load/store request (wmask==0 -> load)
//   dbus__rdy/rdata             : load/store completion pulse + data
//   mem__req/addr/wmask/wdata   : registered shared memory request
//   mem__ack/rdata              : memory completion + read data
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ibus__req,
  input  logic [ADDR_W-1:0]   ibus__addr,
  output logic                ibus__rdy,
  output logic [DATA_W-1:0]   ibus__rdata,
  input  logic                dbus__req,
  input  logic [ADDR_W-1:0]   dbus__addr,
  input  logic [DATA_W/8-1:0] dbus__wmask,
  input  logic [DATA_W-1:0]   dbus__wdata,
  output logic                dbus__rdy,
  output logic [DATA_W-1:0]   dbus__rdata,
  output logic                mem__req,
  output logic [ADDR_W-1:0]   mem__addr,
  output logic [DATA_W/8-1:0] mem__wmask,
  output logic [DATA_W-1:0]   mem__wdata,
  input  logic                mem__ack,
  input  logic [DATA_W-1:0]   mem__rdata
);

  arb_state_t state;
  logic       last_d;
  logic [1:0] grant;

  rr_pick2 u_pick (
    .req   ({dbus__req, ibus__req}),
    .last  (last_d),
    .grant (grant)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_d     <= 1'b0;
      mem__addr  <= '0;
      mem__wmask <= '0;
      mem__wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Payload is captured only here, so it holds until the ack.
          if (grant[1]) begin
            state      <= GRANT_D;
            mem__addr  <= dbus__addr;
            mem__wmask <= dbus__wmask;
            mem__wdata <= dbus__wdata;
          end else if (grant[0]) begin
            state      <= GRANT_I;
            mem__addr  <= ibus__addr;
            mem__wmask <= '0;
            mem__wdata <= '0;
          end
        end
        GRANT_I, GRANT_D: begin
          if (mem__ack) begin
            state  <= IDLE;
            last_d <= (state == GRANT_D);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Derived from registered state only: no input-to-mem__* path.
  assign mem__req = (state != IDLE);

  // rst gating suppresses the pulse while a reset is aborting a grant.
  assign ibus__rdy   = rst && (state == GRANT_I) && mem__ack;
  assign dbus__rdy   = rst && (state == GRANT_D) && mem__ack;
  assign ibus__rdata = ibus__rdy ? mem__rdata : '0;
  assign dbus__rdata = dbus__rdy ? mem__rdata : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: transaction-level model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ibus__req;
  logic [31:0] ibus__addr;
  logic        ibus__rdy;
  logic [31:0] ibus__rdata;
  logic        dbus__req;
  logic [31:0] dbus__addr;
  logic [3:0]  dbus__wmask;
  logic [31:0] dbus__wdata;
  logic        dbus__rdy;
  logic [31:0] dbus__rdata;
  logic        mem__req;
  logic [31:0] mem__addr;
  logic [3:0]  mem__wmask;
  logic [31:0] mem__wdata;
  logic        mem__ack;
  logic [31:0] mem__rdata;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .ibus__req(ibus__req), .ibus__addr(ibus__addr),
    .ibus__rdy(ibus__rdy), .ibus__rdata(ibus__rdata),
    .dbus__req(dbus__req), .dbus__addr(dbus__addr),
    .dbus__wmask(dbus__wmask), .dbus__wdata(dbus__wdata),
    .dbus__rdy(dbus__rdy), .dbus__rdata(dbus__rdata),
    .mem__req(mem__req), .mem__addr(mem__addr),
    .mem__wmask(mem__wmask), .mem__wdata(mem__wdata),
    .mem__ack(mem__ack), .mem__rdata(mem__rdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Transaction model: who owns the memory port (0 none, 1 ibus, 2 dbus),
  // who was served most recently, and the payload the owner asked for.
  int          m_owner = 0;
  int          m_last  = 0;   // 2 -> dbus served last
  logic [31:0] m_addr;
  logic [3:0]  m_wmask;
  logic [31:0] m_wdata;

  always @(posedge clk) begin
    if (!rst) begin
      m_owner = 0;
      m_last  = 0;
    end else if (m_owner == 0) begin
      if (ibus__req && dbus__req) m_owner = (m_last == 2) ? 1 : 2;
      else if (dbus__req)         m_owner = 2;
      else if (ibus__req)         m_owner = 1;
      if (m_owner == 2) begin
        m_addr = dbus__addr; m_wmask = dbus__wmask; m_wdata = dbus__wdata;
      end else if (m_owner == 1) begin
        m_addr = ibus__addr; m_wmask = 4'h0; m_wdata = 32'h0;
      end
    end else if (mem__ack) begin
      m_last  = m_owner;
      m_owner = 0;
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    logic ei, ed;
    ei = rst && (m_owner == 1) && mem__ack;
    ed = rst && (m_owner == 2) && mem__ack;
    chk("m_mem_req", mem__req, (m_owner != 0));
    chk("m_ibus_rdy", ibus__rdy, ei);
    chk("m_dbus_rdy", dbus__rdy, ed);
    if (m_owner != 1 || ei) chk("m_ibus_rdata", ibus__rdata, ei ? mem__rdata : 32'h0);
    if (m_owner != 2 || ed) chk("m_dbus_rdata", dbus__rdata, ed ? mem__rdata : 32'h0);
    if (m_owner != 0) begin
      chk("m_mem_addr", mem__addr, m_addr);
      chk("m_mem_wmask", mem__wmask, m_wmask);
      chk("m_mem_wdata", mem__wdata, m_wdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int   grants[$];
    int   n_rdy;
    rst = 1'b0; ibus__req = 1'b1; dbus__req = 1'b1;
    ibus__addr = 32'h40; dbus__addr = 32'h80; dbus__wmask = 4'h3; dbus__wdata = 32'h1234;
    mem__ack = 1'b0; mem__rdata = 32'h0;

    // Reset held 2 cycles with both requests high.
    #1;
    chk("rst_rdy_i", ibus__rdy, 1'b0);
    chk("rst_rdy_d", dbus__rdy, 1'b0);
    step(); chk("rst_mem_req0", mem__req, 1'b0);
    step(); chk("rst_mem_req1", mem__req, 1'b0);
    chk("rst_addr", mem__addr, 32'h0);
    ibus__req = 1'b0; dbus__req = 1'b0; rst = 1'b1;
    step();

    // Single fetch.
    ibus__req = 1'b1; ibus__addr = 32'h100;
    step();
    chk("f_mem_req", mem__req, 1'b1);
    chk("f_addr", mem__addr, 32'h100);
    chk("f_wmask", mem__wmask, 4'h0);
    mem__ack = 1'b1; mem__rdata = 32'h13; #1;
    chk("f_rdy", ibus__rdy, 1'b1);
    chk("f_rdata", ibus__rdata, 32'h13);
    chk("f_drdy", dbus__rdy, 1'b0);
    step();
    ibus__req = 1'b0; mem__ack = 1'b0; #1;
    chk("f_done", mem__req, 1'b0);
    step();

    // Store with ack delayed 5 cycles.
    dbus__req = 1'b1; dbus__addr = 32'h2000; dbus__wmask = 4'hF; dbus__wdata = 32'hDEADBEEF;
    mem__rdata = 32'h55;
    step();
    n_rdy = 0;
    for (int c = 0; c < 5; c++) begin
      chk("s_addr", mem__addr, 32'h2000);
      chk("s_wdata", mem__wdata, 32'hDEADBEEF);
      chk("s_wmask", mem__wmask, 4'hF);
      if (dbus__rdy) n_rdy++;
      step();
    end
    mem__ack = 1'b1; #1;
    if (dbus__rdy) n_rdy++;
    step();
    dbus__req = 1'b0; mem__ack = 1'b0; #1;
    if (dbus__rdy) n_rdy++;
    chk("s_pulses", n_rdy, 1);
    step();

    // Requester drops req before ack; transaction still completes.
    ibus__req = 1'b1; ibus__addr = 32'h300;
    step();
    ibus__req = 1'b0;
    step(); step();
    mem__ack = 1'b1; mem__rdata = 32'hA5A5; #1;
    chk("drop_rdy", ibus__rdy, 1'b1);
    chk("drop_rdata", ibus__rdata, 32'hA5A5);
    step();
    mem__ack = 1'b0;
    step();

    // Contention: both held, memory acks immediately; last served was ibus.
    ibus__req = 1'b1; ibus__addr = 32'h40;
    dbus__req = 1'b1; dbus__addr = 32'h80; dbus__wmask = 4'h3; dbus__wdata = 32'h77;
    for (int c = 0; c < 40 && grants.size() < 4; c++) begin
      step();
      mem__ack = mem__req; mem__rdata = 32'h1000 + c; #1;
      chk("c_overlap", ibus__rdy && dbus__rdy, 1'b0);
      if (dbus__rdy) grants.push_back(2);
      if (ibus__rdy) grants.push_back(1);
    end
    ibus__req = 1'b0; dbus__req = 1'b0;
    step();
    mem__ack = 1'b0;
    chk("c_count", grants.size(), 4);
    for (int k = 0; k < 4 && k < grants.size(); k++)
      chk("c_order", grants[k], (k % 2 == 0) ? 2 : 1);
    step();

    // Abort: reset lands during GRANT_D, ack arrives with and after it.
    dbus__req = 1'b1; dbus__addr = 32'h4000; dbus__wmask = 4'h0;
    step();
    chk("a_granted", mem__req, 1'b1);
    dbus__req = 1'b0; rst = 1'b0; mem__ack = 1'b1; #1;
    chk("a_rdy_in_rst", dbus__rdy, 1'b0);
    step();
    rst = 1'b1; #1;
    chk("a_rdy_after", dbus__rdy, 1'b0);
    chk("a_mem_req", mem__req, 1'b0);
    step();
    chk("a_idle", mem__req, 1'b0);
    mem__ack = 1'b0;
    step();

    // Spurious ack in IDLE.
    mem__ack = 1'b1; mem__rdata = 32'hFFFF; #1;
    chk("sp_rdy_i", ibus__rdy, 1'b0);
    chk("sp_rdy_d", dbus__rdy, 1'b0);
    step();
    chk("sp_mem_req", mem__req, 1'b0);
    mem__ack = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
